operand_collect_stage: RTL and testbench

Parametrised successor to the decode-side pipeline stage. It buffers up to BUFFER_DEPTH decoded instructions, reads NUM_SOURCES register-file ports for the head entry, and holds each operand once it has been read uncontended. It releases the instruction to execute only when all of its operands are present. It sits between decode and execute, uses the existing prev_done/stall_prev and done_next/next_stall handshake, adds a synchronous flush for control-flow redirects, and has no combinational path from next_stall to stall_prev.

---
 rtl/operand_collect_stage.sv | 210 +++++++++++++++++++++
 tb/tb_operand_collect_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_collect_stage.sv
`default_nettype none
// ============================================================================
//  Module   : operand_collect_stage
//  Purpose  : Buffers decoded instructions between decode and execute. It
//             collects register-file operands for the head entry and holds
//             each operand once it has been read without contention. The
//             head is released downstream only when every used operand is
//             available.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                      : clock, single domain
//    rst                      : synchronous active-high reset
//    prev_done / stall_prev   : upstream offer / stage refuses input
//    payload_in               : opaque decoded fields, passed through
//    source_index_in          : per-source register index, source i at [i*W +: W]
//    source_valid_in          : per-source "operand is used" flags
//    register_read            : read indices for the head entry (0 when empty)
//    register_read_data       : register file data, same cycle
//    register_read_contended  : per-port "data not yet valid" flags
//    flush                    : discard all buffered instructions
//    done_next / next_stall   : head offered downstream / downstream refuses
//    payload_out              : head payload (0 when empty)
//    operand_data             : head operands (captured, live or 0)
//    operand_valid            : head source_valid flags (0 when empty)
// ============================================================================
module operand_collect_stage #(
    parameter int DATA_WIDTH              = 32,
    parameter int REGISTER_INDEXING_WIDTH = 5,
    parameter int NUM_SOURCES             = 2,
    parameter int PAYLOAD_WIDTH           = 64,
    parameter int BUFFER_DEPTH            = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           prev_done,
    output logic                                           stall_prev,
    input  logic [PAYLOAD_WIDTH-1:0]                       payload_in,
    input  logic [NUM_SOURCES*REGISTER_INDEXING_WIDTH-1:0] source_index_in,
    input  logic [NUM_SOURCES-1:0]                         source_valid_in,
    output logic [NUM_SOURCES*REGISTER_INDEXING_WIDTH-1:0] register_read,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]              register_read_data,
    input  logic [NUM_SOURCES-1:0]                         register_read_contended,
    input  logic                                           flush,
    output logic                                           done_next,
    input  logic                                           next_stall,
    output logic [PAYLOAD_WIDTH-1:0]                       payload_out,
    output logic [NUM_SOURCES*DATA_WIDTH-1:0]              operand_data,
    output logic [NUM_SOURCES-1:0]                         operand_valid
);

    localparam int c_ptr_w = $clog2(BUFFER_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_idx_w = NUM_SOURCES * REGISTER_INDEXING_WIDTH;
    localparam int c_dat_w = NUM_SOURCES * DATA_WIDTH;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(BUFFER_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0]       count_q,  count_d;
    logic [c_ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]       wr_ptr_q, wr_ptr_d;

    logic [PAYLOAD_WIDTH-1:0] payload_mem_q  [BUFFER_DEPTH];
    logic [PAYLOAD_WIDTH-1:0] payload_mem_d  [BUFFER_DEPTH];
    logic [c_idx_w-1:0]       index_mem_q    [BUFFER_DEPTH];
    logic [c_idx_w-1:0]       index_mem_d    [BUFFER_DEPTH];
    logic [NUM_SOURCES-1:0]   valid_mem_q    [BUFFER_DEPTH];
    logic [NUM_SOURCES-1:0]   valid_mem_d    [BUFFER_DEPTH];
    logic [NUM_SOURCES-1:0]   captured_mem_q [BUFFER_DEPTH];
    logic [NUM_SOURCES-1:0]   captured_mem_d [BUFFER_DEPTH];
    logic [c_dat_w-1:0]       data_mem_q     [BUFFER_DEPTH];
    logic [c_dat_w-1:0]       data_mem_d     [BUFFER_DEPTH];

    // ------------------------------------------------------------------
    // Head view
    // ------------------------------------------------------------------
    logic                     w_head_valid;
    logic [PAYLOAD_WIDTH-1:0] w_head_payload;
    logic [c_idx_w-1:0]       w_head_index;
    logic [NUM_SOURCES-1:0]   w_head_src_valid;
    logic [NUM_SOURCES-1:0]   w_head_captured;
    logic [c_dat_w-1:0]       w_head_data;
    logic [NUM_SOURCES-1:0]   w_src_ready;
    logic                     w_transfer_prev;
    logic                     w_transfer_next;

    assign w_head_valid     = (count_q != '0);
    assign w_head_payload   = payload_mem_q[rd_ptr_q];
    assign w_head_index     = index_mem_q[rd_ptr_q];
    assign w_head_src_valid = valid_mem_q[rd_ptr_q];
    assign w_head_captured  = captured_mem_q[rd_ptr_q];
    assign w_head_data      = data_mem_q[rd_ptr_q];

    // stall_prev uses only registered occupancy plus flush/rst, so there is
    // no combinational path from next_stall back to upstream.
    assign stall_prev      = (count_q == c_depth) || flush || rst;
    assign done_next       = w_head_valid && (&w_src_ready) && !flush;
    assign w_transfer_prev = prev_done && !stall_prev;
    assign w_transfer_next = done_next && !next_stall;

    assign payload_out   = w_head_valid ? w_head_payload   : '0;
    assign operand_valid = w_head_valid ? w_head_src_valid : '0;

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            // A source is satisfied if unused, already held, or readable now.
            assign w_src_ready[gi] = !w_head_src_valid[gi]
                                   || w_head_captured[gi]
                                   || !register_read_contended[gi];

            assign register_read[gi*REGISTER_INDEXING_WIDTH +: REGISTER_INDEXING_WIDTH] =
                w_head_valid ? w_head_index[gi*REGISTER_INDEXING_WIDTH +: REGISTER_INDEXING_WIDTH]
                             : '0;

            // Held value wins over live data so a later write cannot disturb it.
            assign operand_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                !w_head_valid          ? '0 :
                w_head_captured[gi]    ? w_head_data[gi*DATA_WIDTH +: DATA_WIDTH] :
                w_head_src_valid[gi]   ? register_read_data[gi*DATA_WIDTH +: DATA_WIDTH] :
                                         '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        payload_mem_d  = payload_mem_q;
        index_mem_d    = index_mem_q;
        valid_mem_d    = valid_mem_q;
        captured_mem_d = captured_mem_q;
        data_mem_d     = data_mem_q;

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            for (int e = 0; e < BUFFER_DEPTH; e++) begin
                captured_mem_d[e] = '0;
            end
        end else begin
            // Capture is pointless for an entry leaving this cycle.
            if (w_head_valid && !w_transfer_next) begin
                for (int i = 0; i < NUM_SOURCES; i++) begin
                    if (w_head_src_valid[i] && !w_head_captured[i]
                        && !register_read_contended[i]) begin
                        captured_mem_d[rd_ptr_q][i] = 1'b1;
                        data_mem_d[rd_ptr_q][i*DATA_WIDTH +: DATA_WIDTH] =
                            register_read_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            if (w_transfer_next) begin
                captured_mem_d[rd_ptr_q] = '0;
                rd_ptr_d                 = rd_ptr_q + c_ptr_w'(1);
            end

            // The write slot never aliases the head: pushes are refused when
            // full, and an empty buffer has no head to capture into.
            if (w_transfer_prev) begin
                payload_mem_d[wr_ptr_q]  = payload_in;
                index_mem_d[wr_ptr_q]    = source_index_in;
                valid_mem_d[wr_ptr_q]    = source_valid_in;
                captured_mem_d[wr_ptr_q] = '0;
                wr_ptr_d                 = wr_ptr_q + c_ptr_w'(1);
            end

            case ({w_transfer_prev, w_transfer_next})
                2'b10:   count_d = count_q + c_cnt_w'(1);
                2'b01:   count_d = count_q - c_cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int e = 0; e < BUFFER_DEPTH; e++) begin
                payload_mem_q[e]  <= '0;
                index_mem_q[e]    <= '0;
                valid_mem_q[e]    <= '0;
                captured_mem_q[e] <= '0;
                data_mem_q[e]     <= '0;
            end
        end else begin
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            payload_mem_q  <= payload_mem_d;
            index_mem_q    <= index_mem_d;
            valid_mem_q    <= valid_mem_d;
            captured_mem_q <= captured_mem_d;
            data_mem_q     <= data_mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_collect_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_collect_stage
//  Purpose  : Directed vector table followed by randomized traffic compared
//             against a queue-based reference of the collect stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_collect_stage;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int NS    = 2;
    localparam int PW    = 64;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             prev_done;
    logic             stall_prev;
    logic [PW-1:0]    payload_in;
    logic [NS*RW-1:0] source_index_in;
    logic [NS-1:0]    source_valid_in;
    logic [NS*RW-1:0] register_read;
    logic [NS*DW-1:0] register_read_data;
    logic [NS-1:0]    register_read_contended;
    logic             flush;
    logic             done_next;
    logic             next_stall;
    logic [PW-1:0]    payload_out;
    logic [NS*DW-1:0] operand_data;
    logic [NS-1:0]    operand_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_collect_stage #(
        .DATA_WIDTH              (DW),
        .REGISTER_INDEXING_WIDTH (RW),
        .NUM_SOURCES             (NS),
        .PAYLOAD_WIDTH           (PW),
        .BUFFER_DEPTH            (DEPTH)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .prev_done               (prev_done),
        .stall_prev              (stall_prev),
        .payload_in              (payload_in),
        .source_index_in         (source_index_in),
        .source_valid_in         (source_valid_in),
        .register_read           (register_read),
        .register_read_data      (register_read_data),
        .register_read_contended (register_read_contended),
        .flush                   (flush),
        .done_next               (done_next),
        .next_stall              (next_stall),
        .payload_out             (payload_out),
        .operand_data            (operand_data),
        .operand_valid           (operand_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: queue of pending instructions ----
    typedef struct {
        logic [PW-1:0]    pay;
        logic [NS*RW-1:0] idx;
        logic [NS-1:0]    sv;
        logic [NS-1:0]    cap;
        logic [NS*DW-1:0] cdat;
    } ent_t;

    ent_t mq[$];

    task automatic model_eval(output logic e_stall, output logic e_done,
                              output logic [PW-1:0] e_pay, output logic [NS*DW-1:0] e_opd,
                              output logic [NS-1:0] e_ov, output logic [NS*RW-1:0] e_rr);
        ent_t h;
        bit   allr;
        e_stall = (mq.size() == DEPTH) || flush || rst;
        e_done = 1'b0; e_pay = '0; e_opd = '0; e_ov = '0; e_rr = '0;
        if (mq.size() > 0) begin
            h     = mq[0];
            e_pay = h.pay;
            e_ov  = h.sv;
            e_rr  = h.idx;
            allr  = 1'b1;
            for (int s = 0; s < NS; s++) begin
                if (h.sv[s] && !h.cap[s] && register_read_contended[s]) allr = 1'b0;
                if (h.cap[s])     e_opd[s*DW +: DW] = h.cdat[s*DW +: DW];
                else if (h.sv[s]) e_opd[s*DW +: DW] = register_read_data[s*DW +: DW];
            end
            e_done = allr && !flush;
        end
    endtask

    task automatic model_step();
        logic          es, ed;
        logic [PW-1:0] ep;
        logic [NS*DW-1:0] eo;
        logic [NS-1:0] ev;
        logic [NS*RW-1:0] er;
        bit   tn, tp;
        ent_t h, n;
        model_eval(es, ed, ep, eo, ev, er);
        if (rst || flush) begin
            mq.delete();
        end else begin
            tn = ed && !next_stall;
            tp = prev_done && !es;
            if (mq.size() > 0 && !tn) begin
                h = mq[0];
                for (int s = 0; s < NS; s++) begin
                    if (h.sv[s] && !h.cap[s] && !register_read_contended[s]) begin
                        h.cap[s] = 1'b1;
                        h.cdat[s*DW +: DW] = register_read_data[s*DW +: DW];
                    end
                end
                mq[0] = h;
            end
            if (tn) void'(mq.pop_front());
            if (tp) begin
                n.pay = payload_in; n.idx = source_index_in; n.sv = source_valid_in;
                n.cap = '0; n.cdat = '0;
                mq.push_back(n);
            end
        end
    endtask

    // ---------------- directed vector table ------------------------------
    typedef struct {
        int               lvl;   // 0: no check, 1: stall/done, 2: all outputs
        logic             rst;
        logic             pd;
        logic [PW-1:0]    pay;
        logic [NS*RW-1:0] idx;
        logic [NS-1:0]    sv;
        logic [NS*DW-1:0] rd;
        logic [NS-1:0]    cont;
        logic             fl;
        logic             ns;
        logic             e_stall;
        logic             e_done;
        logic [PW-1:0]    e_pay;
        logic [NS*DW-1:0] e_opd;
        logic [NS-1:0]    e_ov;
        logic [NS*RW-1:0] e_rr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int lvl, input logic r, input logic pd,
                                input logic [PW-1:0] pay, input logic [NS*RW-1:0] idx,
                                input logic [NS-1:0] sv, input logic [NS*DW-1:0] rd,
                                input logic [NS-1:0] cont, input logic fl, input logic ns,
                                input logic es, input logic ed, input logic [PW-1:0] ep,
                                input logic [NS*DW-1:0] eo, input logic [NS-1:0] ev,
                                input logic [NS*RW-1:0] er);
        vec_t v;
        v.lvl = lvl; v.rst = r; v.pd = pd; v.pay = pay; v.idx = idx; v.sv = sv;
        v.rd = rd; v.cont = cont; v.fl = fl; v.ns = ns;
        v.e_stall = es; v.e_done = ed; v.e_pay = ep; v.e_opd = eo; v.e_ov = ev; v.e_rr = er;
        return v;
    endfunction

    localparam logic [NS*RW-1:0] IDX35 = 10'h0A3;   // src0=r3, src1=r5
    localparam logic [NS*RW-1:0] IDX12 = 10'h041;   // src0=r1, src1=r2
    localparam logic [NS*DW-1:0] RD_S  = 64'h0000DEAD_00000077;
    localparam logic [NS*DW-1:0] OP_S  = 64'h00000000_00000077;

    initial begin
        logic          es, ed;
        logic [PW-1:0] ep;
        logic [NS*DW-1:0] eo;
        logic [NS-1:0] ev;
        logic [NS*RW-1:0] er;

        rst = 1'b1; prev_done = 1'b0; payload_in = '0; source_index_in = '0;
        source_valid_in = '0; register_read_data = '0; register_read_contended = '0;
        flush = 1'b0; next_stall = 1'b0;

        // reset held three cycles with an offer pending
        tbl.push_back(mk(0,1,1,64'hFF,IDX35,2'b11,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(2,1,1,64'hFF,IDX35,2'b11,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(2,1,1,64'hFF,IDX35,2'b11,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(2,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // single issue
        tbl.push_back(mk(2,0,1,64'hA5,IDX35,2'b11,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(2,0,0,0,0,0,64'h00000022_00000011,0,0,0,
                         0,1,64'hA5,64'h00000022_00000011,2'b11,IDX35));
        tbl.push_back(mk(2,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // contention on src0 for three cycles; src1 held from the first
        tbl.push_back(mk(2,0,1,64'hB6,IDX35,2'b11,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(2,0,0,0,0,0,64'h00000022_00000033,2'b01,0,0,
                         0,0,64'hB6,64'h00000022_00000033,2'b11,IDX35));
        tbl.push_back(mk(2,0,0,0,0,0,64'h00000099_00000044,2'b01,0,0,
                         0,0,64'hB6,64'h00000022_00000044,2'b11,IDX35));
        tbl.push_back(mk(2,0,0,0,0,0,64'h00000099_00000055,2'b11,0,0,
                         0,0,64'hB6,64'h00000022_00000055,2'b11,IDX35));
        tbl.push_back(mk(2,0,0,0,0,0,64'h00000099_00000066,2'b00,0,0,
                         0,1,64'hB6,64'h00000022_00000066,2'b11,IDX35));
        tbl.push_back(mk(2,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // streaming four instructions, only src0 used
        tbl.push_back(mk(2,0,1,64'h1,IDX12,2'b01,RD_S,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(2,0,1,64'h2,IDX12,2'b01,RD_S,0,0,0, 0,1,64'h1,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,1,64'h3,IDX12,2'b01,RD_S,0,0,0, 0,1,64'h2,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,1,64'h4,IDX12,2'b01,RD_S,0,0,0, 0,1,64'h3,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,0,0,0,0,RD_S,0,0,0,             0,1,64'h4,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // backpressure: fill, refuse third, drain in order
        tbl.push_back(mk(2,0,1,64'h10,IDX12,2'b01,RD_S,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(2,0,1,64'h11,IDX12,2'b01,RD_S,0,0,1, 0,1,64'h10,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,1,64'h12,IDX12,2'b01,RD_S,0,0,1, 1,1,64'h10,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,1,64'h12,IDX12,2'b01,RD_S,0,0,0, 1,1,64'h10,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,1,64'h12,IDX12,2'b01,RD_S,0,0,0, 0,1,64'h11,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,0,0,0,0,RD_S,0,0,0,               0,1,64'h12,OP_S,2'b01,IDX12));
        tbl.push_back(mk(2,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // flush with two entries buffered and an offer pending
        tbl.push_back(mk(2,0,1,64'h20,IDX12,2'b01,RD_S,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(2,0,1,64'h21,IDX12,2'b01,RD_S,0,0,1, 0,1,64'h20,OP_S,2'b01,IDX12));
        tbl.push_back(mk(1,0,1,64'h22,IDX12,2'b01,RD_S,0,1,0, 1,0,0,0,0,0));
        tbl.push_back(mk(2,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            rst = tbl[k].rst; prev_done = tbl[k].pd; payload_in = tbl[k].pay;
            source_index_in = tbl[k].idx; source_valid_in = tbl[k].sv;
            register_read_data = tbl[k].rd; register_read_contended = tbl[k].cont;
            flush = tbl[k].fl; next_stall = tbl[k].ns;
            #1;
            if (tbl[k].lvl >= 1) begin
                chk($sformatf("row%0d stall_prev", k), 64'(stall_prev), 64'(tbl[k].e_stall));
                chk($sformatf("row%0d done_next", k),  64'(done_next),  64'(tbl[k].e_done));
            end
            if (tbl[k].lvl >= 2) begin
                chk($sformatf("row%0d payload_out", k),   payload_out,          tbl[k].e_pay);
                chk($sformatf("row%0d operand_data", k),  operand_data,         tbl[k].e_opd);
                chk($sformatf("row%0d operand_valid", k), 64'(operand_valid),   64'(tbl[k].e_ov));
                chk($sformatf("row%0d register_read", k), 64'(register_read),   64'(tbl[k].e_rr));
            end
            model_step();
        end

        // ---------------- randomized traffic vs reference ----------------
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            rst             = ($urandom_range(0, 63) == 0);
            flush           = ($urandom_range(0, 31) == 0);
            prev_done       = ($urandom_range(0, 9) < 6);
            next_stall      = ($urandom_range(0, 9) < 3);
            payload_in      = {$urandom, $urandom};
            source_index_in = NS*RW'($urandom);
            source_valid_in = NS'($urandom);
            register_read_data = {$urandom, $urandom};
            for (int s = 0; s < NS; s++)
                register_read_contended[s] = ($urandom_range(0, 2) == 0);
            #1;
            model_eval(es, ed, ep, eo, ev, er);
            chk($sformatf("rnd%0d stall_prev", n),    64'(stall_prev),    64'(es));
            chk($sformatf("rnd%0d done_next", n),     64'(done_next),     64'(ed));
            chk($sformatf("rnd%0d payload_out", n),   payload_out,        ep);
            chk($sformatf("rnd%0d operand_data", n),  operand_data,       eo);
            chk($sformatf("rnd%0d operand_valid", n), 64'(operand_valid), 64'(ev));
            chk($sformatf("rnd%0d register_read", n), 64'(register_read), 64'(er));
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
